// File: rtl/regfile_write_arbiter.sv
// Round-robin arbiter sharing the register file write port between
// writeback requesters. The granted write is staged for one cycle in the
// output register. Also tracks pending writes and counts R0 discards.
module regfile_write_arbiter #(
   parameter int NUM_REQ = 2,
   parameter int ADDR_W  = 3,
   parameter int DATA_W  = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        hold,
   input  logic [NUM_REQ-1:0]          req_valid,
   input  logic [NUM_REQ*ADDR_W-1:0]   req_addr,
   input  logic [NUM_REQ*DATA_W-1:0]   req_data,
   output logic [NUM_REQ-1:0]          req_ready,
   output logic [ADDR_W-1:0]           reg_write,
   output logic                        reg_write_signal,
   output logic [DATA_W-1:0]           in_data,
   output logic [1:0]                  grant_id,
   output logic [(2**ADDR_W)-1:0]      pending,
   output logic [7:0]                  r0_drop_count
);

   localparam int NREG = 2**ADDR_W;

   logic [1:0]        ptr;
   logic [1:0]        gnt_idx;
   logic [1:0]        idx;
   logic [2:0]        sum;
   logic              found;
   logic [3:0]        valid4;
   logic [3:0]        ready4;
   logic [ADDR_W-1:0] addr_a [4];
   logic [DATA_W-1:0] data_a [4];
   logic [ADDR_W-1:0] sel_addr;
   logic [DATA_W-1:0] sel_data;
   logic [NREG-1:0]   pend_nxt;
   logic              xfer;

   // Requesters padded to four slots so a 2-bit index always fits exactly.
   assign valid4 = 4'(req_valid);

   for (genvar g = 0; g < 4; g++) begin : g_unpack
      if (g < NUM_REQ) begin : g_used
         assign addr_a[g] = req_addr[g*ADDR_W +: ADDR_W];
         assign data_a[g] = req_data[g*DATA_W +: DATA_W];
      end else begin : g_pad
         assign addr_a[g] = '0;
         assign data_a[g] = '0;
      end
   end

   // Scan from the pointer, wrapping mod NUM_REQ, for the first valid requester.
   always_comb begin
      found   = 1'b0;
      gnt_idx = '0;
      idx     = '0;
      sum     = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         sum = {1'b0, ptr} + 3'(k);
         if (sum >= 3'(NUM_REQ)) sum = sum - 3'(NUM_REQ);
         idx = sum[1:0];
         if (!found && valid4[idx]) begin
            found   = 1'b1;
            gnt_idx = idx;
         end
      end
   end

   // Single ready bit, suppressed during stall and reset.
   always_comb begin
      ready4 = '0;
      if (found && !hold && !rst) ready4[gnt_idx] = 1'b1;
   end

   assign req_ready = ready4[NUM_REQ-1:0];
   assign xfer      = |ready4;
   assign sel_addr  = addr_a[gnt_idx];
   assign sel_data  = data_a[gnt_idx];

   // One-hot of the accepted destination; R0 never shows as pending.
   always_comb begin
      pend_nxt = '0;
      if (sel_addr != '0) pend_nxt[sel_addr] = 1'b1;
   end

   // Output stage: load on transfer, otherwise drop the enable and keep the rest.
   always_ff @(posedge clk) begin
      if (rst) begin
         reg_write        <= '0;
         reg_write_signal <= 1'b0;
         in_data          <= '0;
         grant_id         <= '0;
         pending          <= '0;
      end else if (xfer) begin
         reg_write        <= sel_addr;
         reg_write_signal <= (sel_addr != '0);
         in_data          <= sel_data;
         grant_id         <= gnt_idx;
         pending          <= pend_nxt;
      end else begin
         reg_write_signal <= 1'b0;
         pending          <= '0;
      end
   end

   // Round-robin pointer moves past the last winner; frozen otherwise.
   always_ff @(posedge clk) begin
      if (rst)       ptr <= '0;
      else if (xfer) ptr <= (gnt_idx == 2'(NUM_REQ-1)) ? 2'd0 : gnt_idx + 2'd1;
   end

   // Saturating count of accepted writes aimed at R0.
   always_ff @(posedge clk) begin
      if (rst)
         r0_drop_count <= '0;
      else if (xfer && sel_addr == '0 && r0_drop_count != 8'hFF)
         r0_drop_count <= r0_drop_count + 8'd1;
   end

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// Bench for regfile_write_arbiter: directed scenarios followed by random
// traffic, all checked against a transaction-level model.
module tb_regfile_write_arbiter;

   localparam int N  = 2;
   localparam int AW = 3;
   localparam int DW = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              hold;
   logic [N-1:0]      req_valid;
   logic [N*AW-1:0]   req_addr;
   logic [N*DW-1:0]   req_data;
   logic [N-1:0]      req_ready;
   logic [AW-1:0]     reg_write;
   logic              reg_write_signal;
   logic [DW-1:0]     in_data;
   logic [1:0]        grant_id;
   logic [(2**AW)-1:0] pending;
   logic [7:0]        r0_drop_count;

   regfile_write_arbiter #(.NUM_REQ(N), .ADDR_W(AW), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst), .hold(hold),
      .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
      .req_ready(req_ready), .reg_write(reg_write),
      .reg_write_signal(reg_write_signal), .in_data(in_data),
      .grant_id(grant_id), .pending(pending), .r0_drop_count(r0_drop_count)
   );

   always #5 clk = ~clk;

   // Requester-side state
   logic          rv [N];
   logic [AW-1:0] ra [N];
   logic [DW-1:0] rd [N];

   // Reference model
   int            m_ptr;
   logic [AW-1:0] m_wa;
   logic [DW-1:0] m_wd;
   logic          m_we;
   int            m_gid;
   int            m_cnt;

   int            n_chk = 0;
   int            n_err = 0;
   logic [31:0]   last_ready;
   int            last_gnt;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic apply();
      for (int i = 0; i < N; i++) begin
         req_valid[i]         = rv[i];
         req_addr[i*AW +: AW] = ra[i];
         req_data[i*DW +: DW] = rd[i];
      end
   endtask

   // Index of the requester that should win this cycle, or -1.
   function automatic int model_pick();
      if (rst || hold) return -1;
      for (int k = 0; k < N; k++) begin
         int j;
         j = (m_ptr + k) % N;
         if (rv[j]) return j;
      end
      return -1;
   endfunction

   task automatic model_reset();
      m_ptr = 0; m_wa = '0; m_wd = '0; m_we = 1'b0; m_gid = 0; m_cnt = 0;
   endtask

   // One clock: check ready mid-cycle, advance model at the edge, check outputs after.
   task automatic step();
      int g;
      logic [31:0] er;
      logic [31:0] ep;
      @(negedge clk);
      g  = model_pick();
      er = (g < 0) ? 32'd0 : (32'd1 << g);
      last_ready = 32'(req_ready);
      last_gnt   = g;
      chk("req_ready", last_ready, er);
      @(posedge clk);
      if (rst) model_reset();
      else if (g >= 0) begin
         m_wa  = ra[g];
         m_wd  = rd[g];
         m_gid = g;
         m_we  = (ra[g] != 0);
         if (ra[g] == 0 && m_cnt < 255) m_cnt++;
         m_ptr = (g + 1) % N;
      end else m_we = 1'b0;
      #1;
      ep = m_we ? (32'd1 << m_wa) : 32'd0;
      chk("reg_write_signal", 32'(reg_write_signal), 32'(m_we));
      chk("reg_write", 32'(reg_write), 32'(m_wa));
      chk("in_data", 32'(in_data), 32'(m_wd));
      chk("grant_id", 32'(grant_id), 32'(m_gid));
      chk("pending", 32'(pending), ep);
      chk("r0_drop_count", 32'(r0_drop_count), 32'(m_cnt));
   endtask

   initial begin
      int exp_g [4];
      int exp_a [4];
      model_reset();
      for (int i = 0; i < N; i++) begin rv[i] = 1'b0; ra[i] = '0; rd[i] = '0; end
      req_valid = '0; req_addr = '0; req_data = '0;
      rst = 1'b1; hold = 1'b0;
      apply();

      // Reset then idle
      step(); step();
      chk("reset_ready", last_ready, 32'd0);
      rst = 1'b0;
      step();

      // Single requester
      rv[0] = 1'b1; ra[0] = 3'd3; rd[0] = 8'hA5; apply();
      step();
      chk("single_ready", last_ready, 32'd1);
      chk("single_addr", 32'(reg_write), 32'd3);
      chk("single_data", 32'(in_data), 32'hA5);
      chk("single_pending", 32'(pending), 32'h08);
      rv[0] = 1'b0; apply();
      step();
      chk("single_after_we", 32'(reg_write_signal), 32'd0);

      // Round robin from a fresh pointer
      rst = 1'b1; step(); rst = 1'b0;
      rv[0] = 1'b1; ra[0] = 3'd1; rd[0] = 8'h11;
      rv[1] = 1'b1; ra[1] = 3'd2; rd[1] = 8'h22; apply();
      exp_g = '{0, 1, 0, 1};
      exp_a = '{1, 2, 1, 2};
      for (int c = 0; c < 4; c++) begin
         step();
         chk("rr_grant", 32'(grant_id), 32'(exp_g[c]));
         chk("rr_addr", 32'(reg_write), 32'(exp_a[c]));
         chk("rr_we", 32'(reg_write_signal), 32'd1);
      end

      // R0 discards and saturation
      rv[0] = 1'b0; rv[1] = 1'b1; ra[1] = 3'd0; rd[1] = 8'hFF; apply();
      for (int c = 0; c < 3; c++) begin
         step();
         chk("r0_ready", last_ready, 32'd2);
      end
      chk("r0_count3", 32'(r0_drop_count), 32'd3);
      for (int c = 0; c < 251; c++) step();
      chk("r0_count254", 32'(r0_drop_count), 32'd254);
      for (int c = 0; c < 3; c++) step();
      chk("r0_count_sat", 32'(r0_drop_count), 32'd255);

      // Hold after one grant
      rv[0] = 1'b1; ra[0] = 3'd1; rd[0] = 8'h11;
      rv[1] = 1'b1; ra[1] = 3'd2; rd[1] = 8'h22; apply();
      step();
      chk("hold_first_grant", last_ready, 32'd1);
      hold = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         chk("hold_ready", last_ready, 32'd0);
         chk("hold_we", 32'(reg_write_signal), 32'd0);
      end
      hold = 1'b0;
      step();
      chk("hold_resume", last_ready, 32'd2);

      // Reset mid-operation
      rv[1] = 1'b0; ra[0] = 3'd5; rd[0] = 8'h55; apply();
      step();
      chk("mid_we", 32'(reg_write_signal), 32'd1);
      rst = 1'b1; rv[1] = 1'b1; apply();
      step();
      chk("mid_rst_we", 32'(reg_write_signal), 32'd0);
      chk("mid_rst_pending", 32'(pending), 32'd0);
      rst = 1'b0;
      step();
      chk("mid_after_ready", last_ready, 32'd1);

      // Random traffic with requesters obeying the hold-until-accepted rule
      for (int c = 0; c < 400; c++) begin
         for (int i = 0; i < N; i++) begin
            if (last_gnt == i) rv[i] = 1'b0;
            if (!rv[i] && $urandom_range(0, 3) != 0) begin
               rv[i] = 1'b1;
               ra[i] = AW'($urandom);
               rd[i] = DW'($urandom);
            end
         end
         hold = ($urandom_range(0, 4) == 0);
         rst  = ($urandom_range(0, 60) == 0);
         apply();
         step();
      end

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/regfile_write_arbiter.md
Name: regfile_write_arbiter

Overview:
Shares the single write port of the 8x8 register file between several writeback requesters (e.g. ALU result, memory load, link/immediate path). Round-robin arbitration with per-requester valid/ready handshake. Granted write is staged in one output register that drives the register file's write address, write-enable and data inputs. Also exposes a pending-write scoreboard for hazard logic and a saturating counter of writes discarded because they target R0.

Parameters:
NUM_REQ, 2, number of requesters; legal 2..4
ADDR_W, 3, register address width; register count = 2**ADDR_W
DATA_W, 8, register data width

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous reset, active-high
hold  input  1  pipeline stall; no new grant while high
req_valid  input  NUM_REQ  bit i: requester i presents a write
req_addr  input  NUM_REQ*ADDR_W  requester i destination in bits [i*ADDR_W +: ADDR_W]
req_data  input  NUM_REQ*DATA_W  requester i data in bits [i*DATA_W +: DATA_W]
req_ready  output  NUM_REQ  one-hot or zero; bit i high = requester i accepted this cycle
reg_write  output  ADDR_W  register file write address (staged)
reg_write_signal  output  1  register file write enable (staged)
in_data  output  DATA_W  register file write data (staged)
grant_id  output  2  index of requester owning the staged write
pending  output  2**ADDR_W  bit r high = staged write to register r not yet committed
r0_drop_count  output  8  saturating count of accepted writes that targeted R0

Behaviour:
- Reset (rst high at rising edge): reg_write=0, reg_write_signal=0, in_data=0, grant_id=0, pending=0, r0_drop_count=0, round-robin pointer=0. req_ready=0 while rst high.
- Arbitration (combinational from registered pointer): when hold=0 and any req_valid, req_ready is the first valid requester scanning ptr, ptr+1, ... mod NUM_REQ. Never more than one bit set. With hold=1 or no valid, req_ready=0.
- Handshake: transfer occurs when req_valid[i] & req_ready[i] at a rising edge. Requester holds valid/addr/data stable until transferred. Output stage is always free: the register file commits each cycle, so one acceptance per cycle is sustainable with no bubbles.
- Pointer: on transfer from i, ptr <= (i+1) mod NUM_REQ. Otherwise it is unchanged.
- Staging, latency 1: transfer at edge N loads reg_write=addr, in_data=data, grant_id=i.
  - reg_write_signal=1 during cycle N..N+1 if addr!=0.
  - Register file commits at edge N+1.
  - No transfer at edge N: reg_write_signal<=0. reg_write, in_data and grant_id hold their old values.
- R0: a transfer with addr=0 is accepted (ready asserted) but reg_write_signal<=0. r0_drop_count increments and saturates at 255.
- pending: after edge N, pending equals the one-hot of the staged addr when reg_write_signal=1, else 0. Cleared when the next edge has no transfer.
- hold asserted mid-stream: a staged write already in the register still commits; no new grant while hold=1. Pointer frozen. Arbitration resumes the cycle hold falls.
- Simultaneous requests to the same address from different requesters are serialized in grant order. The later one overwrites; there is no merging.
- Reset mid-operation: the staged write is discarded (reg_write_signal=0 after the edge) and is not committed.

Test Plan:
- Reset then idle: rst=1 for 2 cycles, all valid=0 -> all outputs 0, req_ready=0, pending=0.
- Single requester: req_valid=01, addr0=3, data0=0xA5 -> req_ready=01 same cycle. Next cycle reg_write=3, in_data=0xA5, reg_write_signal=1, pending=0x08, grant_id=0. Cycle after: reg_write_signal=0, pending=0.
- Round-robin fairness: both valid continuously, req0 addr 1/data 0x11, req1 addr 2/data 0x22 -> grants alternate 0,1,0,1. reg_write sequence 1,2,1,2 with reg_write_signal=1 every cycle.
- R0 discard: req1 writes addr 0 data 0xFF three times -> req_ready pulses, reg_write_signal stays 0, r0_drop_count=3. Preload the count to 254 and issue three more -> count saturates at 255.
- Hold: both valid, hold=1 for 3 cycles after one grant -> staged write commits once, then req_ready=0 and reg_write_signal=0 for the hold window. Pointer unchanged, so the other requester is granted first when hold=0.
- Reset mid-operation: grant req0 addr 5, assert rst at the next edge -> reg_write_signal=0, pending=0, ptr=0. After release, req0 is granted first when both are valid.
